// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, 4-digit result plus overflow flag.
// Build option: define BIN2BCD_SAT_EN to saturate bcd at 16'h9999 on overflow instead of wrapping mod 10000.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf
);

  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [BIN_W-1:0] opnd;
  logic [16:0]      scr;
  logic [15:0]      scr_adj;
  logic [CW-1:0]    cnt;

  // Digits never exceed 9 before adjustment, so +3 cannot carry between digits.
  always_comb begin
    scr_adj = scr[15:0];
    for (int unsigned d = 0; d < 4; d++) begin
      if (scr[4*d +: 4] >= 4'd5) begin
        scr_adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opnd  <= '0;
      scr   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opnd  <= bin;
            scr   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted scratch and operand shift as one register; operand MSB enters units.
          scr  <= {scr_adj, opnd[BIN_W-1]};
          opnd <= {opnd[BIN_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          ovf  <= scr[16];
`ifdef BIN2BCD_SAT_EN
          bcd  <= scr[16] ? 16'h9999 : scr[15:0];
`else
          bcd  <= scr[15:0];
`endif
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 14, binary input width; legal range 4..14.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  conversion request, sampled on rising clk edge.
REQ-005 SHALL provide port bin  input  BIN_W  unsigned binary operand, captured only when start is accepted.
REQ-006 SHALL provide port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL provide port done  output  1  one-cycle pulse marking new bcd/ovf values.
REQ-008 SHALL provide port bcd  output  16  packed BCD result: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; drives the downstream 4-digit display num input.
REQ-009 SHALL provide port ovf  output  1  operand exceeded 9999.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after BIN_W shift cycles, DONE->IDLE unconditionally.
REQ-011 SHALL accept start only in IDLE (busy low); at the accepting edge it loads bin into a shift register, clears a 17-bit BCD scratch (4 digits plus ten-thousands bit) and the shift counter.
REQ-012 SHALL ignore start while busy is high; bin changes after capture SHALL NOT affect the result.
REQ-013 In SHIFT, each cycle SHALL first add 3 to every scratch BCD digit >= 5, then shift scratch and operand left one bit together (double dabble), once per cycle.
REQ-014 SHALL perform exactly BIN_W shift cycles, counted by a counter of ceil(log2(BIN_W+1)) bits.
REQ-015 busy SHALL be high from the edge after start acceptance until the edge where done rises.
REQ-016 On the DONE edge, bcd and ovf SHALL be registered and done SHALL be high for exactly one cycle; latency from start-sampling edge to done high = BIN_W+1 cycles (15 at default).
REQ-017 bcd and ovf SHALL hold their last values between done pulses.
REQ-018 ovf SHALL be high when the ten-thousands scratch bit is nonzero (operand > 9999), else low.
REQ-019 A start asserted during the done cycle SHALL be accepted at the next edge; minimum start-to-start period = BIN_W+2 cycles.
REQ-020 Operand 0 SHALL yield bcd 16'h0000, ovf 0.

Reset
REQ-021 When rst is high at a clk edge, state SHALL become IDLE; busy, done, ovf = 0; bcd = 16'h0000; counter and scratch cleared.
REQ-022 rst SHALL take priority over start at the same edge.
REQ-023 rst during SHIFT SHALL abort the conversion with no done pulse; bcd SHALL read 16'h0000.

Configuration
REQ-024 Macro BIN2BCD_SAT_EN SHALL select overflow handling.
REQ-025 With BIN2BCD_SAT_EN defined: when ovf is set, bcd SHALL be forced to 16'h9999.
REQ-026 Without BIN2BCD_SAT_EN: when ovf is set, bcd SHALL carry the low four digits (operand mod 10000).
REQ-027 ovf generation and all timing SHALL be identical in both configurations.

Verification
REQ-028 rst then start with bin=4321 -> after 15 cycles done=1 for one cycle, bcd=16'h4321, ovf=0.
REQ-029 bin=0, then bin=9999 back-to-back (start on done cycle) -> bcd 16'h0000 then 16'h9999, ovf=0, done pulses 16 cycles apart.
REQ-030 bin=12345 -> ovf=1; bcd=16'h2345 without BIN2BCD_SAT_EN, 16'h9999 with it.
REQ-031 start=1 held throughout and bin changed to 7 mid-conversion of 4321 -> single done with 16'h4321, next conversion 0007 starts only after IDLE.
REQ-032 rst asserted 5 cycles into a conversion of 4321 -> no done pulse, busy=0, bcd=16'h0000 next cycle; subsequent start converts normally.
